// File: rtl/watch_mode_ctrl.sv
// watch_mode_ctrl
//   Front-panel controller for the watch. It turns the three debounced
//   button levels into the display mode (CLOCK, SET_HOUR, SET_MIN,
//   STOPWATCH) and generates the one-cycle increment/clear pulses, the
//   stopwatch run level and the blink enable for the field being edited.
//
// Ports
//   i_clk       system clock, rising edge
//   i_rst       synchronous active-high reset
//   i_tick_1k   one-cycle strobe at 1 kHz
//   i_key_mode  debounced MODE level (1 = pressed)
//   i_key_set   debounced SET level
//   i_key_up    debounced UP level
//   o_mode      0 = CLOCK, 1 = SET_HOUR, 2 = SET_MIN, 3 = STOPWATCH
//   o_inc_hour  one-cycle pulse: hour +1
//   o_inc_min   one-cycle pulse: minute +1
//   o_sec_clr   one-cycle pulse: clear seconds
//   o_sw_run    stopwatch run level
//   o_sw_clr    one-cycle pulse: clear stopwatch
//   o_blink     display enable for the edited field
module watch_mode_ctrl #(
  parameter int LONG_MS   = 1000,
  parameter int REPEAT_MS = 200,
  parameter int BLINK_MS  = 500
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_tick_1k,
  input  logic       i_key_mode,
  input  logic       i_key_set,
  input  logic       i_key_up,
  output logic [1:0] o_mode,
  output logic       o_inc_hour,
  output logic       o_inc_min,
  output logic       o_sec_clr,
  output logic       o_sw_run,
  output logic       o_sw_clr,
  output logic       o_blink
);

  localparam int HOLD_MAX = (LONG_MS > REPEAT_MS) ? LONG_MS : REPEAT_MS;
  localparam int HW       = $clog2(HOLD_MAX + 1);
  localparam int BW       = $clog2(BLINK_MS + 1);

  localparam logic [HW-1:0] LONG_THR   = HW'(LONG_MS);
  localparam logic [HW-1:0] REPEAT_THR = HW'(REPEAT_MS);
  localparam logic [BW-1:0] BLINK_THR  = BW'(BLINK_MS);

  typedef enum logic [1:0] {
    MODE_CLOCK     = 2'd0,
    MODE_SET_HOUR  = 2'd1,
    MODE_SET_MIN   = 2'd2,
    MODE_STOPWATCH = 2'd3
  } mode_t;

  mode_t          r_mode;
  logic           r_ready;
  logic           r_keyModeQ;
  logic           r_keySetQ;
  logic           r_keyUpQ;
  logic           r_incHour;
  logic           r_incMin;
  logic           r_secClr;
  logic           r_swClr;
  logic           r_swRun;
  logic           r_blink;
  logic           r_repeat;
  logic [HW-1:0]  r_holdCnt;
  logic [BW-1:0]  r_blinkCnt;

  logic           w_modePress;
  logic           w_setPress;
  logic           w_upPress;
  logic           w_inSet;
  logic           w_editing;
  logic [HW-1:0]  w_holdInc;
  logic [HW-1:0]  w_holdThr;
  logic           w_holdHit;
  logic           w_incFire;
  logic [BW-1:0]  w_blinkInc;

  // Rising-edge press detect with fixed priority MODE > SET > UP; the
  // ready flag masks a key that was already held when reset released.
  assign w_modePress = r_ready & i_key_mode & ~r_keyModeQ;
  assign w_setPress  = r_ready & i_key_set  & ~r_keySetQ & ~w_modePress;
  assign w_upPress   = r_ready & i_key_up   & ~r_keyUpQ  & ~w_modePress & ~w_setPress;

  // w_editing: sitting in a set state and not leaving it this cycle.
  assign w_inSet    = (r_mode == MODE_SET_HOUR) || (r_mode == MODE_SET_MIN);
  assign w_editing  = w_inSet & ~w_modePress & ~w_setPress;

  // The first auto-repeat waits LONG_MS ticks, later ones REPEAT_MS.
  assign w_holdInc  = r_holdCnt + HW'(1);
  assign w_holdThr  = r_repeat ? REPEAT_THR : LONG_THR;
  assign w_holdHit  = w_editing & i_key_up & i_tick_1k & (w_holdInc == w_holdThr);
  assign w_incFire  = w_editing & (w_upPress | w_holdHit);
  assign w_blinkInc = r_blinkCnt + BW'(1);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mode     <= MODE_CLOCK;
      r_ready    <= 1'b0;
      r_keyModeQ <= 1'b0;
      r_keySetQ  <= 1'b0;
      r_keyUpQ   <= 1'b0;
      r_incHour  <= 1'b0;
      r_incMin   <= 1'b0;
      r_secClr   <= 1'b0;
      r_swClr    <= 1'b0;
      r_swRun    <= 1'b0;
      r_blink    <= 1'b1;
      r_repeat   <= 1'b0;
      r_holdCnt  <= '0;
      r_blinkCnt <= '0;
    end else begin
      r_ready    <= 1'b1;
      r_keyModeQ <= i_key_mode;
      r_keySetQ  <= i_key_set;
      r_keyUpQ   <= i_key_up;
      r_incHour  <= 1'b0;
      r_incMin   <= 1'b0;
      r_secClr   <= 1'b0;
      r_swClr    <= 1'b0;

      case (r_mode)
        MODE_CLOCK: begin
          if (w_modePress)     r_mode <= MODE_STOPWATCH;
          else if (w_setPress) r_mode <= MODE_SET_HOUR;
        end
        MODE_SET_HOUR: begin
          if (w_modePress)     r_mode <= MODE_CLOCK;
          else if (w_setPress) r_mode <= MODE_SET_MIN;
          else if (w_incFire)  r_incHour <= 1'b1;
        end
        MODE_SET_MIN: begin
          if (w_modePress) begin
            r_mode <= MODE_CLOCK;
          end else if (w_setPress) begin
            r_mode   <= MODE_CLOCK;
            r_secClr <= 1'b1;
          end else if (w_incFire) begin
            r_incMin <= 1'b1;
          end
        end
        MODE_STOPWATCH: begin
          // sw_run is left alone on exit so the stopwatch keeps running.
          if (w_modePress)                   r_mode  <= MODE_CLOCK;
          else if (w_setPress && !r_swRun)   r_swClr <= 1'b1;
          else if (w_upPress)                r_swRun <= ~r_swRun;
        end
      endcase

      // Hold counter only runs while UP is held inside a set state; any
      // release or mode change drops it back to the long first delay.
      if (w_editing && i_key_up) begin
        if (i_tick_1k) begin
          if (w_holdHit) begin
            r_holdCnt <= '0;
            r_repeat  <= 1'b1;
          end else begin
            r_holdCnt <= w_holdInc;
          end
        end
      end else begin
        r_holdCnt <= '0;
        r_repeat  <= 1'b0;
      end

      // Blink restarts solid on set-state entry and on every increment so
      // the edited field is visible right after it changes.
      if (w_editing) begin
        if (w_incFire) begin
          r_blink    <= 1'b1;
          r_blinkCnt <= '0;
        end else if (i_tick_1k) begin
          if (w_blinkInc == BLINK_THR) begin
            r_blink    <= ~r_blink;
            r_blinkCnt <= '0;
          end else begin
            r_blinkCnt <= w_blinkInc;
          end
        end
      end else begin
        r_blink    <= 1'b1;
        r_blinkCnt <= '0;
      end
    end
  end

  assign o_mode     = r_mode;
  assign o_inc_hour = r_incHour;
  assign o_inc_min  = r_incMin;
  assign o_sec_clr  = r_secClr;
  assign o_sw_run   = r_swRun;
  assign o_sw_clr   = r_swClr;
  assign o_blink    = r_blink;

endmodule
